// File: rtl/fetch_pkg.sv
// Shared types, opcode constants and immediate helpers for the PC fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [10:0] OP_HLT   = 11'b11010100010;
    localparam logic [4:0]  COND_LT  = 5'b01011;

    // Sign-extends the low 'width' bits of imm and scales by 4: left-align the
    // field at bit 63, then arithmetic-shift it back down to bit 2.
    function automatic logic [63:0] sext_shift2(input logic [25:0] imm,
                                                input int unsigned width);
        logic signed [63:0] v;
        v = $signed({imm, 38'b0} << (26 - width));
        return 64'(v >>> (62 - width));
    endfunction

    function automatic logic is_hlt(input logic [31:0] instr);
        return (instr[31:21] == OP_HLT) && (instr[4:0] == 5'b00000);
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC resolution for sequential flow, B, BL, BR, CBZ and B.LT.
module branch_target_calc
    import fetch_pkg::*;
(
    input  logic [63:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_alu_zero,
    input  logic        i_flag_negative,
    input  logic        i_flag_overflow,
    input  logic [63:0] i_br_target,
    output logic [63:0] o_next_pc
);

    logic [63:0] w_seq_pc;
    logic [63:0] w_imm26_pc;
    logic [63:0] w_imm19_pc;

    assign w_seq_pc   = i_pc + 64'd4;
    assign w_imm26_pc = i_pc + sext_shift2(i_instr[25:0], 26);
    assign w_imm19_pc = i_pc + sext_shift2({7'b0, i_instr[23:5]}, 19);

    always_comb begin
        o_next_pc = w_seq_pc;
        if ((i_instr[31:26] == OP_B) || (i_instr[31:26] == OP_BL)) begin
            o_next_pc = w_imm26_pc;
        end else if (i_instr[31:21] == OP_BR) begin
            o_next_pc = {i_br_target[63:2], 2'b00};
        end else if (i_instr[31:24] == OP_CBZ) begin
            if (i_alu_zero) begin
                o_next_pc = w_imm19_pc;
            end
        end else if ((i_instr[31:24] == OP_BCOND) && (i_instr[4:0] == COND_LT)) begin
            // LT means N != V, using the flags exactly as the datapath holds them.
            if (i_flag_negative ^ i_flag_overflow) begin
                o_next_pc = w_imm19_pc;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, run-control FSM (fill/run/halt) and retired-instruction counter.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [31:0]          imem_data,
    input  logic                 alu_zero,
    input  logic                 flag_negative,
    input  logic                 flag_overflow,
    input  logic [63:0]          br_target,
    output logic [63:0]          imem_addr,
    output logic [31:0]          instruction,
    output logic                 instr_valid,
    output logic [63:0]          link_addr,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    state_t               r_state;
    state_t               w_state_next;
    logic [63:0]          r_pc;
    logic [CNT_WIDTH-1:0] r_retired;
    logic [63:0]          w_next_pc;
    logic                 w_advance;
    logic                 w_is_hlt;

    assign w_is_hlt = is_hlt(imem_data);

    branch_target_calc u_branch_target_calc (
        .i_pc            (r_pc),
        .i_instr         (imem_data),
        .i_alu_zero      (alu_zero),
        .i_flag_negative (flag_negative),
        .i_flag_overflow (flag_overflow),
        .i_br_target     (br_target),
        .o_next_pc       (w_next_pc)
    );

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            S_FILL: begin
                if (!stall) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    if (w_is_hlt) w_state_next = S_HALT;
                    else          w_advance    = 1'b1;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_FILL;
            r_pc      <= RESET_PC;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_advance) begin
                r_pc      <= w_next_pc;
                r_retired <= r_retired + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs are gated by reset so nothing commits while reset is held low.
    assign instr_valid = (r_state == S_RUN) && reset;
    assign halted      = (r_state == S_HALT) && reset;
    assign instruction = instr_valid ? imem_data : 32'h0;
    assign imem_addr   = r_pc;
    assign link_addr   = r_pc + 64'd4;
    assign retired     = r_retired;

endmodule
